// File: rtl/wifi_cmd_rx.sv
// UART (8N1) command receiver for the WiFi module: recovers a byte from rx and
// turns 'D'/'A'/'E' into single-cycle alarm commands, counting framing errors.
module wifi_cmd_rx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] inWIFI,
    output logic       cmd_strobe,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic [3:0]    code_n;
    logic          stb_n, ferr_n;
    logic [7:0]    errc_n;

    // Synchronizer resets to the idle-high line level so reset never fakes a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            inWIFI     <= 4'b0000;
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            inWIFI     <= code_n;
            cmd_strobe <= stb_n;
            frame_err  <= ferr_n;
            err_count  <= errc_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        code_n  = 4'b0000;
        stb_n   = 1'b0;
        ferr_n  = 1'b0;
        errc_n  = err_count;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = HALF;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        state_n = DATA;
                        cnt_n   = FULL;
                        bit_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sh_n  = {rxs, shreg[7:1]};
                    cnt_n = FULL;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        state_n = IDLE;
                        case (shreg)
                            8'h44:   code_n = 4'b1010;
                            8'h41:   code_n = 4'b1011;
                            8'h45:   code_n = 4'b1100;
                            default: code_n = 4'b0000;
                        endcase
                        stb_n = |code_n;
                    end else begin
                        state_n = WAIT_IDLE;
                        ferr_n  = 1'b1;
                        if (err_count != 8'hFF) errc_n = err_count + 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
